// File: rtl/weight_fifo_loader_if.sv
// Weight FIFO loader bus: upstream row handshake, FIFO push/pop strobes
// and tile-load control.
interface weight_fifo_loader_if #(
  parameter int CNT_W = 3
);
  logic             w_valid;
  logic             w_ready;
  logic [15:0]      w_data;
  logic             push_col0;
  logic             push_col1;
  logic [7:0]       data_out;
  logic             load_start;
  logic             pop;
  logic             load_busy;
  logic             load_done;
  logic             load_reject;
  logic [CNT_W-1:0] rows_valid;

  modport master (
    output w_valid, w_data, load_start,
    input  w_ready, push_col0, push_col1, data_out,
    input  pop, load_busy, load_done, load_reject,
    input  rows_valid
  );

  modport slave (
    input  w_valid, w_data, load_start,
    output w_ready, push_col0, push_col1, data_out,
    output pop, load_busy, load_done, load_reject,
    output rows_valid
  );
endinterface

// File: rtl/weight_fifo_loader.sv
// Serialises weight rows onto the dual-column FIFO bus and pops
// ROWS-deep tiles into the MMU, tracking FIFO occupancy.
module weight_fifo_loader #(
  parameter int DEPTH = 4,
  parameter int ROWS  = 2,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  weight_fifo_loader_if.slave bus
);

  typedef enum logic [1:0] {
    P_IDLE,
    P_COL0,
    P_COL1
  } p_state_t;

  typedef enum logic [1:0] {
    L_IDLE,
    L_POP,
    L_SKEW,
    L_DONE
  } l_state_t;

  p_state_t         p_q, p_d;
  l_state_t         l_q, l_d;
  logic             ready_en_q;
  logic [15:0]      row_q;
  logic [7:0]       data_q;
  logic [CNT_W-1:0] resv_q;
  logic [CNT_W-1:0] rows_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reject_q, reject_d;
  logic             w_ready;
  logic             accept;
  logic             popping;
  logic             pushed;

  // Pops in flight are not credited until the cycle after.
  assign w_ready = ready_en_q
                 & (p_q != P_COL0)
                 & (resv_q < CNT_W'(DEPTH));
  assign accept  = bus.w_valid & w_ready;
  assign popping = (l_q == L_POP);
  assign pushed  = (p_q == P_COL1);

  always_comb begin
    p_d = p_q;
    unique case (p_q)
      P_IDLE:  if (accept) p_d = P_COL0;
      P_COL0:  p_d = P_COL1;
      P_COL1:  p_d = accept ? P_COL0 : P_IDLE;
      default: p_d = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q        <= P_IDLE;
      ready_en_q <= 1'b0;
      row_q      <= '0;
      data_q     <= '0;
    end else begin
      p_q        <= p_d;
      ready_en_q <= 1'b1;
      if (accept) begin
        row_q  <= bus.w_data;
        data_q <= bus.w_data[7:0];
      end else if (p_q == P_COL0) begin
        data_q <= row_q[15:8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resv_q <= '0;
      rows_q <= '0;
    end else begin
      resv_q <= resv_q + CNT_W'(accept) - CNT_W'(popping);
      rows_q <= rows_q + CNT_W'(pushed) - CNT_W'(popping);
    end
  end

  always_comb begin
    l_d      = l_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
    unique case (l_q)
      L_IDLE: begin
        if (bus.load_start) begin
          if (rows_q >= CNT_W'(ROWS)) begin
            l_d   = L_POP;
            cnt_d = '0;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      L_POP: begin
        if (cnt_q == CNT_W'(ROWS - 1)) l_d = L_SKEW;
        else cnt_d = cnt_q + 1'b1;
      end
      L_SKEW:  l_d = L_DONE;
      L_DONE:  l_d = L_IDLE;
      default: l_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_q      <= L_IDLE;
      cnt_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      l_q      <= l_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
    end
  end

  assign bus.w_ready     = w_ready;
  assign bus.push_col0   = (p_q == P_COL0);
  assign bus.push_col1   = (p_q == P_COL1);
  assign bus.data_out    = data_q;
  assign bus.pop         = popping;
  assign bus.load_busy   = (l_q == L_POP) | (l_q == L_SKEW);
  assign bus.load_done   = (l_q == L_DONE);
  assign bus.load_reject = reject_q;
  assign bus.rows_valid  = rows_q;

endmodule
